// File: rtl/link_tx_scheduler.sv
// rtl/link_tx_scheduler.sv - master-side transmit scheduler for the two-board link
//
// Sequences state-broadcast (5 bytes) and acknowledge (2 bytes) packets onto a
// shared UART transmitter and runs a frame-based receive watchdog.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   frame_tick           per-frame pulse, requests a state broadcast
//   p1_hp, p2_hp         player health, sampled on frame_tick
//   game_state           game FSM state, sampled on frame_tick
//   rx_data, rx_valid    byte from the mirror; each one requests an ack
//   tx_ready             UART idle
//   tx_data, tx_start    byte launch towards the UART
//   link_up              mirror heard from within LINK_TIMEOUT frames
//   overrun              pulse when a frame_tick request is dropped
//   busy                 a packet is in flight
module link_tx_scheduler #(
    parameter logic [7:0] SYNC_STATE   = 8'hA5,
    parameter logic [7:0] SYNC_ACK     = 8'h5A,
    parameter int         LINK_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [7:0] p1_hp,
    input  logic [7:0] p2_hp,
    input  logic [2:0] game_state,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       link_up,
    output logic       overrun,
    output logic       busy
);

    localparam logic [7:0] WD_MAX = 8'(LINK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_READY
    } state_t;

    state_t     state, state_next;

    logic       state_pend;
    logic       ack_pend;
    logic [7:0] ack_byte;

    // Pending snapshot: always takes the newest frame_tick values. The packet
    // in flight is sent from pkt_b*, copied at selection time, so later ticks
    // can never corrupt a packet already on the wire.
    logic [2:0] pend_gs;
    logic [7:0] pend_p1;
    logic [7:0] pend_p2;

    logic [7:0] pkt_b0, pkt_b1, pkt_b2, pkt_b3, pkt_b4;
    logic [2:0] pkt_last;
    logic [2:0] idx;

    logic [7:0] wd_cnt;

    logic       sel_ack;
    logic       sel_state;
    logic [7:0] cur_byte;

    always_comb begin
        cur_byte = pkt_b0;
        case (idx)
            3'd1:    cur_byte = pkt_b1;
            3'd2:    cur_byte = pkt_b2;
            3'd3:    cur_byte = pkt_b3;
            3'd4:    cur_byte = pkt_b4;
            default: cur_byte = pkt_b0;
        endcase
    end

    always_comb begin
        state_next = state;
        sel_ack    = 1'b0;
        sel_state  = 1'b0;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (ack_pend) begin
                    sel_ack    = 1'b1;
                    state_next = S_ISSUE;
                end else if (state_pend) begin
                    sel_state  = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_data = cur_byte;
                if (tx_ready) begin
                    tx_start   = 1'b1;
                    state_next = S_WAIT_LOW;
                end
            end
            // The UART needs a cycle before it drops tx_ready.
            S_WAIT_LOW: state_next = S_WAIT_READY;
            S_WAIT_READY: begin
                if (tx_ready) begin
                    state_next = (idx == pkt_last) ? S_IDLE : S_ISSUE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            state_pend <= 1'b0;
            ack_pend   <= 1'b0;
            ack_byte   <= 8'h00;
            pend_gs    <= 3'd0;
            pend_p1    <= 8'h00;
            pend_p2    <= 8'h00;
            pkt_b0     <= 8'h00;
            pkt_b1     <= 8'h00;
            pkt_b2     <= 8'h00;
            pkt_b3     <= 8'h00;
            pkt_b4     <= 8'h00;
            pkt_last   <= 3'd0;
            idx        <= 3'd0;
            overrun    <= 1'b0;
        end else begin
            state <= state_next;

            // A new request in the selection cycle re-arms the flag.
            if (frame_tick)     state_pend <= 1'b1;
            else if (sel_state) state_pend <= 1'b0;

            if (rx_valid)     ack_pend <= 1'b1;
            else if (sel_ack) ack_pend <= 1'b0;

            if (rx_valid) ack_byte <= rx_data;

            if (frame_tick) begin
                pend_gs <= game_state;
                pend_p1 <= p1_hp;
                pend_p2 <= p2_hp;
            end

            // Dropped only if the old request is not being consumed right now.
            overrun <= frame_tick && state_pend && !sel_state;

            if (sel_ack) begin
                pkt_b0   <= SYNC_ACK;
                pkt_b1   <= ack_byte;
                pkt_last <= 3'd1;
                idx      <= 3'd0;
            end else if (sel_state) begin
                pkt_b0   <= SYNC_STATE;
                pkt_b1   <= {pend_gs, 5'b0};
                pkt_b2   <= pend_p1;
                pkt_b3   <= pend_p2;
                pkt_b4   <= {pend_gs, 5'b0} ^ pend_p1 ^ pend_p2;
                pkt_last <= 3'd4;
                idx      <= 3'd0;
            end else if (state == S_WAIT_READY && tx_ready) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= 8'h00;
            link_up <= 1'b0;
        end else if (rx_valid) begin
            wd_cnt  <= 8'h00;
            link_up <= 1'b1;
        end else if (frame_tick) begin
            if (wd_cnt < WD_MAX) wd_cnt <= wd_cnt + 8'h01;
            if (wd_cnt >= WD_MAX - 8'h01) link_up <= 1'b0;
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb/tb_link_tx_scheduler.sv - scoreboard bench for link_tx_scheduler
module tb_link_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] p1_hp = 8'h00;
    logic [7:0] p2_hp = 8'h00;
    logic [2:0] game_state = 3'd0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       link_up;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    link_tx_scheduler #(
        .SYNC_STATE(8'hA5),
        .SYNC_ACK(8'h5A),
        .LINK_TIMEOUT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .p1_hp(p1_hp),
        .p2_hp(p2_hp),
        .game_state(game_state),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .link_up(link_up),
        .overrun(overrun),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every launched byte.
    always @(negedge clk) begin
        if (overrun === 1'b1) ov_cnt++;
        if (tx_start === 1'b1) begin
            start_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %0h want none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    bad++;
                    $display("FAIL tx_byte: got %0h want %0h", tx_data, e);
                end
            end
        end
    end

    task automatic push_state(input logic [2:0] gs, input logic [7:0] a, input logic [7:0] b, input logic [7:0] ck);
        exp_q.push_back(8'hA5);
        exp_q.push_back({gs, 5'b0});
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(ck);
    endtask

    task automatic tick(input logic [2:0] gs, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        frame_tick = 1'b1; game_state = gs; p1_hp = a; p2_hp = b;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic rx(input logic [7:0] d);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = d;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input string name);
        int n;
        n = 0;
        while (start_cnt < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (start_cnt < target) check(name, start_cnt, target);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0) && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int lows;
        int ov0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_link_up", link_up, 1'b0);
        rst = 1'b0;

        // Single broadcast plus first-byte latency.
        push_state(3'd2, 8'd100, 8'd64, 8'h64);
        tick(3'd2, 8'd100, 8'd64);
        @(negedge clk);
        check("latency_early", tx_start, 1'b0);
        @(negedge clk);
        check("latency_first", tx_start, 1'b1);
        wait_idle("single_drain");

        // Ack priority; busy must stay high across the state packet.
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h07);
        push_state(3'd1, 8'h05, 8'h06, 8'h23);
        base = start_cnt;
        @(posedge clk); #1;
        frame_tick = 1'b1; game_state = 3'd1; p1_hp = 8'h05; p2_hp = 8'h06;
        rx_valid = 1'b1; rx_data = 8'h07;
        @(posedge clk); #1;
        frame_tick = 1'b0; rx_valid = 1'b0;
        check("link_up_after_rx", link_up, 1'b1);
        wait_starts(base + 3, "prio_third");
        lows = 0;
        for (int n = 0; n < 200 && start_cnt < base + 7; n++) begin
            @(negedge clk); #1;
            if (!busy) lows++;
        end
        check("prio_busy_lows", lows, 0);
        wait_idle("prio_drain");

        // Overrun with pending snapshot.
        ov0 = ov_cnt;
        push_state(3'd0, 8'h32, 8'h3C, 8'h0E);
        push_state(3'd0, 8'h0A, 8'h02, 8'h08);
        base = start_cnt;
        tick(3'd0, 8'h32, 8'h3C);
        wait_starts(base + 1, "ovr_first");
        @(posedge clk); #1;
        tx_ready = 1'b0;
        tick(3'd0, 8'h01, 8'h02);
        tick(3'd0, 8'h0A, 8'h02);
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_idle("ovr_drain");
        check("overrun_pulses", ov_cnt - ov0, 1);

        // Backpressure: nothing launches while tx_ready is low.
        push_state(3'd7, 8'hFF, 8'h01, 8'h1E);
        base = start_cnt;
        tick(3'd7, 8'hFF, 8'h01);
        wait_starts(base + 1, "bp_first");
        @(posedge clk); #1;
        tx_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_start", start_cnt, base + 1);
        tx_ready = 1'b1;
        wait_idle("bp_drain");

        // Watchdog, LINK_TIMEOUT=3.
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h11);
        rx(8'h11);
        check("wd_rx_up", link_up, 1'b1);
        wait_idle("wd_ack_drain");
        for (int k = 1; k <= 3; k++) begin
            push_state(3'd0, 8'h00, 8'h00, 8'h00);
            tick(3'd0, 8'h00, 8'h00);
            check($sformatf("wd_tick%0d", k), link_up, (k < 3) ? 1'b1 : 1'b0);
            wait_idle("wd_tick_drain");
        end
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h22);
        rx(8'h22);
        check("wd_recover", link_up, 1'b1);
        wait_idle("wd_recover_drain");

        // Reset mid-packet after the second byte.
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h20);
        base = start_cnt;
        tick(3'd1, 8'h02, 8'h03);
        wait_starts(base + 2, "rst_mid_two");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_tx_data", tx_data, 8'h00);
        check("mid_tx_start", tx_start, 1'b0);
        check("mid_overrun", overrun, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_link_up", link_up, 1'b0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_no_more", start_cnt, base + 2);
        check("mid_queue", exp_q.size(), 0);
        push_state(3'd1, 8'h02, 8'h03, 8'h21);
        tick(3'd1, 8'h02, 8'h03);
        wait_idle("fresh_drain");
        check("fresh_count", start_cnt, base + 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
Master-side transmit scheduler for the two-board link. It sequences every byte the master sends to the mirror board over the shared UART transmitter. It arbitrates between two packet types: the periodic game-state broadcast, triggered once per video frame, and the short acknowledge packet returned for each control byte received from the mirror. It also supervises link health with a frame-based receive watchdog.

Parameters:
SYNC_STATE, 8'hA5, first byte of a state-broadcast packet
SYNC_ACK, 8'h5A, first byte of an acknowledge packet
LINK_TIMEOUT, 30, consecutive frame_ticks without rx_valid before link_up drops (range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_tick  in  1  one-cycle pulse per video frame; requests a state broadcast
p1_hp  in  8  player-1 health, sampled on frame_tick
p2_hp  in  8  player-2 health, sampled on frame_tick
game_state  in  3  game FSM state, sampled on frame_tick
rx_data  in  8  byte received from the mirror
rx_valid  in  1  one-cycle pulse, rx_data valid
tx_ready  in  1  UART transmitter idle and able to accept a byte
tx_data  out  8  byte to transmit, valid while tx_start=1
tx_start  out  1  one-cycle pulse, launches tx_data
link_up  out  1  mirror heard from within LINK_TIMEOUT frames
overrun  out  1  one-cycle pulse when a frame_tick is dropped
busy  out  1  a packet is in flight

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx_data=0, tx_start=0, overrun=0, busy=0, link_up=0.
  - Pending flags cleared, watchdog counter=0, FSM to IDLE.
  - A reset mid-packet abandons the packet; the rest of it is never sent.
- Snapshot: on frame_tick, {game_state, p1_hp, p2_hp} is captured into a snapshot register. If a state packet is in flight, the snapshot register is not overwritten; the new values go to a pending snapshot.
- State packet, 5 bytes in order:
  - SYNC_STATE
  - {game_state, 5'b0}
  - p1_hp
  - p2_hp
  - checksum = XOR of bytes 2..4
- Ack packet, 2 bytes in order:
  - SYNC_ACK
  - echoed rx_data
- Request flags, one deep each:
  - state_pend is set by frame_tick.
  - If frame_tick arrives while state_pend is already set, overrun pulses for one cycle. The newer values replace the pending snapshot.
  - ack_pend is set by rx_valid, which also latches ack_byte=rx_data. A second rx_valid while ack_pend is set overwrites ack_byte; no overrun is flagged.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_READY.
  - IDLE: if ack_pend, select the ack packet; else if state_pend, select the state packet. The ack packet wins when both are pending. Selecting a packet clears its flag the same cycle, then goes to ISSUE. busy=1 from ISSUE until the return to IDLE.
  - ISSUE: wait for tx_ready=1, then drive tx_start=1 for exactly one cycle with the current byte. Go to WAIT_LOW.
  - WAIT_LOW: ignore tx_ready for exactly one cycle, which covers the UART's busy latency. Go to WAIT_READY.
  - WAIT_READY: when tx_ready=1, advance the byte index. If bytes remain, go to ISSUE; otherwise go to IDLE.
- Packets are never interleaved: a request arriving mid-packet waits for IDLE.
- Minimum gap between tx_start pulses is 3 cycles.
- Latency from frame_tick in IDLE (with tx_ready=1) to the first tx_start is 2 cycles: flag set, then select, then ISSUE.
- Simultaneous frame_tick and rx_valid: both flags are set; the ack packet is sent first.
- Watchdog:
  - rx_valid resets the counter to 0 and sets link_up=1.
  - Each frame_tick without rx_valid in the same cycle increments the counter, saturating at LINK_TIMEOUT.
  - When the counter reaches LINK_TIMEOUT, link_up=0.
  - rx_valid and frame_tick in the same cycle: rx_valid wins.
- Width rule: the checksum is 8-bit XOR; there is no carry.

Test Plan:
- Single broadcast: after reset, tx_ready=1 held; frame_tick with game_state=3'd2, p1_hp=8'd100, p2_hp=8'd64 -> tx_start pulses carry A5, 40, 64, 40, 64 in that order; checksum = 40^64^40 = 64.
- Ack priority: frame_tick and rx_valid(rx_data=8'h07) in the same cycle -> bytes 5A, 07 first, then the 5-byte state packet; busy stays high throughout the state packet.
- Overrun and pending snapshot:
  - Hold tx_ready=0 during a packet.
  - Issue two more frame_ticks, the second with p1_hp=8'd10.
  - Required: overrun pulses exactly once; the next state packet carries p1_hp=0A.
- Backpressure: tx_ready held low for 20 cycles after the first byte -> no further tx_start until tx_ready returns; byte order is preserved and no byte is duplicated.
- Watchdog (LINK_TIMEOUT=3): rx_valid once -> link_up=1; three frame_ticks with no rx_valid -> link_up=0 on the third; next rx_valid -> link_up=1.
- Reset mid-packet: assert rst after byte 2 of a state packet -> all outputs return to their reset values the next cycle; the remaining bytes are never sent; a fresh frame_tick then produces a complete 5-byte packet.
